// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types for the hazard scoreboard: shadow-slot layout, FSM encoding,
// and the register-file forwarding select value.
package hazard_pkg;

  // Slot rd field is sized for the widest register index supported; narrower
  // indices are zero-extended on entry and on comparison.
  localparam int RD_MAX_W = 8;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                we;
    logic                is_load;
  } slot_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    CSR_DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Decode-side bundle between the pipeline and the hazard scoreboard.
interface hazard_scoreboard_unit_if #(
  parameter int NSTAGES = 3,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
);
  localparam int SEL_W = $clog2(NSTAGES + 1);

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] id_rd;
  logic             id_rd_we;
  logic             id_is_load;
  logic             id_is_csr;
  logic             mem_wait;
  logic             took_branch;
  logic             excep_or_ret;

  logic [SEL_W-1:0] fwd_sel_a;
  logic [SEL_W-1:0] fwd_sel_b;
  logic             stall_if;
  logic             stall_id;
  logic             flush_if;
  logic             flush_id;
  logic             flush_ex;
  logic             flush_mem;
  logic             csr_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rd_we, id_is_load, id_is_csr, mem_wait, took_branch, excep_or_ret,
    input  fwd_sel_a, fwd_sel_b, stall_if, stall_id, flush_if, flush_id,
           flush_ex, flush_mem, csr_busy, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_rd_we, id_is_load, id_is_csr, mem_wait, took_branch, excep_or_ret,
    output fwd_sel_a, fwd_sel_b, stall_if, stall_id, flush_if, flush_id,
           flush_ex, flush_mem, csr_busy, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard_unit_fwd_match.sv
// Priority match of one source register against the shadow slots; the
// youngest (lowest-numbered) producing slot wins.
module hazard_fwd_match
  import hazard_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int REG_W   = 5,
  parameter int SEL_W   = 2
) (
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_used,
  input  slot_t            i_slots [1:NSTAGES],
  output logic [SEL_W-1:0] o_sel,
  output logic             o_is_load
);

  always_comb begin
    o_sel     = SEL_W'(FWD_RF);
    o_is_load = 1'b0;
    // Walk oldest to youngest so the youngest match overwrites.
    for (int k = NSTAGES; k >= 1; k--) begin
      if (i_used && (i_rs != '0) && i_slots[k].valid && i_slots[k].we &&
          (i_slots[k].rd == RD_MAX_W'(i_rs))) begin
        o_sel     = SEL_W'(k);
        o_is_load = i_slots[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// In-order pipeline hazard scoreboard: forwarding selects, load-use and CSR
// serialisation stalls, memory-wait freeze and branch/trap flush control.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NSTAGES        = 3,
  parameter int REG_W          = 5,
  parameter int LOAD_FWD_STAGE = 2,
  parameter int CNT_W          = 16
) (
  input logic                    clk,
  input logic                    reset_n,
  hazard_scoreboard_unit_if.slave bus
);

  localparam int SEL_W = $clog2(NSTAGES + 1);

  slot_t            r_slot [1:NSTAGES];
  state_e           r_state;
  logic [CNT_W-1:0] r_stall_cnt;

  state_e           w_state_nxt;
  logic [SEL_W-1:0] w_sel_a;
  logic [SEL_W-1:0] w_sel_b;
  logic             w_ld_a;
  logic             w_ld_b;
  logic             w_haz;
  logic             w_any_valid;
  logic             w_csr_req;
  logic             w_stall;
  logic             w_fl_if;
  logic             w_fl_id;
  logic             w_fl_ex;
  logic             w_fl_mem;
  logic             w_issue;
  slot_t            w_id_tag;

  hazard_fwd_match #(.NSTAGES(NSTAGES), .REG_W(REG_W), .SEL_W(SEL_W)) u_match_a (
    .i_rs      (bus.id_rs1),
    .i_used    (bus.id_rs1_used),
    .i_slots   (r_slot),
    .o_sel     (w_sel_a),
    .o_is_load (w_ld_a)
  );

  hazard_fwd_match #(.NSTAGES(NSTAGES), .REG_W(REG_W), .SEL_W(SEL_W)) u_match_b (
    .i_rs      (bus.id_rs2),
    .i_used    (bus.id_rs2_used),
    .i_slots   (r_slot),
    .o_sel     (w_sel_b),
    .o_is_load (w_ld_b)
  );

  // A load is only a hazard while it sits in a stage that cannot yet forward.
  always_comb begin
    w_haz = bus.id_valid &&
            (((w_sel_a != '0) && w_ld_a && (int'(w_sel_a) < LOAD_FWD_STAGE)) ||
             ((w_sel_b != '0) && w_ld_b && (int'(w_sel_b) < LOAD_FWD_STAGE)));
    w_csr_req   = bus.id_valid && bus.id_is_csr;
    w_any_valid = 1'b0;
    for (int k = 1; k <= NSTAGES; k++) begin
      w_any_valid = w_any_valid | r_slot[k].valid;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_fl_if     = 1'b0;
    w_fl_id     = 1'b0;
    w_fl_ex     = 1'b0;
    w_fl_mem    = 1'b0;
    if (bus.mem_wait) begin
      w_stall = 1'b1;
    end else if (bus.took_branch) begin
      w_fl_if     = 1'b1;
      w_fl_id     = 1'b1;
      w_state_nxt = RUN;
    end else if (bus.excep_or_ret) begin
      w_fl_id     = 1'b1;
      w_fl_ex     = 1'b1;
      w_fl_mem    = 1'b1;
      w_state_nxt = RUN;
    end else begin
      unique case (r_state)
        RUN, LOAD_STALL: begin
          if (w_csr_req && w_any_valid) begin
            w_stall     = 1'b1;
            w_state_nxt = CSR_DRAIN;
          end else if (w_haz) begin
            w_stall     = 1'b1;
            w_state_nxt = LOAD_STALL;
          end else begin
            w_state_nxt = RUN;
          end
        end
        CSR_DRAIN: begin
          if (w_any_valid) begin
            w_stall = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    w_issue          = bus.id_valid && !w_stall && !w_fl_id;
    w_id_tag         = '0;
    w_id_tag.valid   = 1'b1;
    w_id_tag.rd      = RD_MAX_W'(bus.id_rd);
    w_id_tag.we      = bus.id_rd_we;
    w_id_tag.is_load = bus.id_is_load;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 1; k <= NSTAGES; k++) begin
        r_slot[k] <= '0;
      end
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (!bus.mem_wait) begin
        r_state   <= w_state_nxt;
        r_slot[1] <= w_issue ? w_id_tag : '0;
        // A trap kills what would have entered MEM as well as EX.
        for (int k = 2; k <= NSTAGES; k++) begin
          r_slot[k] <= ((k == 2) && w_fl_ex) ? '0 : r_slot[k-1];
        end
      end
    end
  end

  assign bus.fwd_sel_a   = reset_n ? w_sel_a : '0;
  assign bus.fwd_sel_b   = reset_n ? w_sel_b : '0;
  assign bus.stall_if    = reset_n && w_stall;
  assign bus.stall_id    = reset_n && w_stall;
  assign bus.flush_if    = reset_n && w_fl_if;
  assign bus.flush_id    = reset_n && w_fl_id;
  assign bus.flush_ex    = reset_n && w_fl_ex;
  assign bus.flush_mem   = reset_n && w_fl_mem;
  assign bus.csr_busy    = reset_n && (r_state == CSR_DRAIN);
  assign bus.stall_count = reset_n ? r_stall_cnt : '0;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with hand-computed expectations.
module tb_hazard_scoreboard_unit;

  localparam int NS  = 3;
  localparam int RW  = 5;
  localparam int LFS = 2;
  localparam int CW  = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  hazard_scoreboard_unit_if #(.NSTAGES(NS), .REG_W(RW), .CNT_W(CW)) bus ();

  hazard_scoreboard_unit #(
    .NSTAGES(NS), .REG_W(RW), .LOAD_FWD_STAGE(LFS), .CNT_W(CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
                    input int rd, input logic we, input logic ld, input logic csr);
    bus.id_valid    = v;
    bus.id_rs1      = RW'(rs1);
    bus.id_rs2      = RW'(rs2);
    bus.id_rs1_used = u1;
    bus.id_rs2_used = u2;
    bus.id_rd       = RW'(rd);
    bus.id_rd_we    = we;
    bus.id_is_load  = ld;
    bus.id_is_csr   = csr;
    #1;
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2);
    id(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic nop();
    id(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.mem_wait     = 1'b1;
    bus.took_branch  = 1'b1;
    bus.excep_or_ret = 1'b0;
    alu(6, 0, 0);
    chk("rst_stall_if", bus.stall_if, 0);
    chk("rst_stall_id", bus.stall_id, 0);
    chk("rst_flush_if", bus.flush_if, 0);
    chk("rst_flush_id", bus.flush_id, 0);
    chk("rst_csr_busy", bus.csr_busy, 0);
    tick();
    tick();
    reset_n          = 1'b1;
    bus.mem_wait     = 1'b0;
    bus.took_branch  = 1'b0;
    nop();
    chk("post_rst_count", bus.stall_count, 0);
    chk("post_rst_stall", bus.stall_id, 0);

    // Back-to-back and one-gap ALU forwarding.
    alu(5, 0, 0);
    tick();
    alu(6, 5, 1);
    chk("fwd_b2b_a", bus.fwd_sel_a, 1);
    chk("fwd_b2b_b", bus.fwd_sel_b, 0);
    chk("fwd_b2b_stall", bus.stall_id, 0);
    tick();
    alu(5, 0, 0);
    tick();
    nop();
    tick();
    alu(7, 5, 6);
    chk("fwd_gap_a", bus.fwd_sel_a, 2);
    chk("fwd_gap_b", bus.fwd_sel_b, 3);
    chk("fwd_gap_stall", bus.stall_id, 0);
    tick();

    // Load-use: one stall cycle, then forward from MEM.
    id(1'b1, 2, 0, 1'b1, 1'b1, 5, 1'b1, 1'b1, 1'b0);
    chk("lw_issue_stall", bus.stall_id, 0);
    tick();
    alu(7, 5, 5);
    chk("lu_stall_id", bus.stall_id, 1);
    chk("lu_stall_if", bus.stall_if, 1);
    chk("lu_sel_a_s1", bus.fwd_sel_a, 1);
    tick();
    alu(7, 5, 5);
    chk("lu_release", bus.stall_id, 0);
    chk("lu_fwd_a", bus.fwd_sel_a, 2);
    chk("lu_fwd_b", bus.fwd_sel_b, 2);
    chk("lu_count", bus.stall_count, 1);
    tick();

    // Youngest producer wins; x0 is never a hazard.
    alu(3, 0, 0);
    tick();
    alu(3, 0, 0);
    tick();
    id(1'b1, 3, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("young_a", bus.fwd_sel_a, 1);
    chk("young_b", bus.fwd_sel_b, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      id(1'b1, 0, 0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    id(1'b1, 0, 0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    chk("x0_a", bus.fwd_sel_a, 0);
    chk("x0_b", bus.fwd_sel_b, 0);
    chk("x0_stall", bus.stall_id, 0);
    tick();

    // CSR serialisation behind three ALU ops.
    alu(10, 0, 0);
    tick();
    alu(11, 0, 0);
    tick();
    alu(12, 0, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      id(1'b1, 0, 0, 1'b1, 1'b1, 13, 1'b1, 1'b0, 1'b1);
      chk($sformatf("csr_stall_id%0d", c), bus.stall_id, 1);
      chk($sformatf("csr_stall_if%0d", c), bus.stall_if, 1);
      chk($sformatf("csr_busy%0d", c), bus.csr_busy, (c == 0) ? 0 : 1);
      tick();
    end
    id(1'b1, 0, 0, 1'b1, 1'b1, 13, 1'b1, 1'b0, 1'b1);
    chk("csr_issue_stall", bus.stall_id, 0);
    chk("csr_issue_busy", bus.csr_busy, 1);
    tick();
    id(1'b1, 13, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("csr_tag_s1", bus.fwd_sel_a, 1);
    chk("csr_done_busy", bus.csr_busy, 0);
    chk("csr_count", bus.stall_count, 4);
    tick();

    // Branch and trap together while in LOAD_STALL: branch wins.
    id(1'b1, 0, 0, 1'b1, 1'b1, 8, 1'b1, 1'b1, 1'b0);
    tick();
    alu(9, 8, 0);
    chk("br_lu_stall", bus.stall_id, 1);
    tick();
    bus.took_branch  = 1'b1;
    bus.excep_or_ret = 1'b1;
    alu(9, 8, 0);
    chk("br_flush_if", bus.flush_if, 1);
    chk("br_flush_id", bus.flush_id, 1);
    chk("br_flush_ex", bus.flush_ex, 0);
    chk("br_flush_mem", bus.flush_mem, 0);
    chk("br_stall", bus.stall_id, 0);
    tick();
    bus.took_branch  = 1'b0;
    bus.excep_or_ret = 1'b0;
    alu(10, 9, 8);
    chk("br_bubble_a", bus.fwd_sel_a, 0);
    chk("br_lw_b", bus.fwd_sel_b, 3);
    chk("br_after_stall", bus.stall_id, 0);
    chk("br_after_flush", bus.flush_id, 0);
    tick();

    // Trap alone: IF keeps fetching the vector, slots 1 and 2 cleared.
    alu(20, 0, 0);
    tick();
    alu(21, 0, 0);
    tick();
    bus.excep_or_ret = 1'b1;
    alu(22, 0, 0);
    chk("ex_flush_if", bus.flush_if, 0);
    chk("ex_flush_id", bus.flush_id, 1);
    chk("ex_flush_ex", bus.flush_ex, 1);
    chk("ex_flush_mem", bus.flush_mem, 1);
    tick();
    bus.excep_or_ret = 1'b0;
    alu(23, 20, 21);
    chk("ex_survivor_a", bus.fwd_sel_a, 3);
    chk("ex_cleared_b", bus.fwd_sel_b, 0);
    tick();

    // Memory wait freezes everything, including a concurrent branch.
    alu(24, 0, 0);
    tick();
    alu(25, 0, 0);
    tick();
    alu(26, 0, 0);
    tick();
    bus.mem_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.took_branch = (i == 1);
      alu(27, 26, 24);
      chk($sformatf("mw_stall_if%0d", i), bus.stall_if, 1);
      chk($sformatf("mw_stall_id%0d", i), bus.stall_id, 1);
      chk($sformatf("mw_fwd_a%0d", i), bus.fwd_sel_a, 1);
      chk($sformatf("mw_fwd_b%0d", i), bus.fwd_sel_b, 3);
      chk($sformatf("mw_flush_if%0d", i), bus.flush_if, 0);
      tick();
    end
    bus.mem_wait    = 1'b0;
    bus.took_branch = 1'b0;
    alu(27, 26, 24);
    chk("mw_done_a", bus.fwd_sel_a, 1);
    chk("mw_done_b", bus.fwd_sel_b, 3);
    chk("mw_done_stall", bus.stall_id, 0);
    chk("mw_count", bus.stall_count, 9);

    // Reset mid-stream.
    reset_n = 1'b0;
    alu(27, 26, 24);
    chk("rst2_fwd_a", bus.fwd_sel_a, 0);
    chk("rst2_fwd_b", bus.fwd_sel_b, 0);
    chk("rst2_count", bus.stall_count, 0);
    chk("rst2_stall_if", bus.stall_if, 0);
    tick();
    reset_n = 1'b1;
    alu(27, 26, 24);
    chk("rst2_empty_a", bus.fwd_sel_a, 0);
    chk("rst2_empty_b", bus.fwd_sel_b, 0);
    chk("rst2_cnt_clr", bus.stall_count, 0);
    chk("rst2_busy", bus.csr_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the in-order pipeline hazard detector.
- Keeps a shadow pipeline of destination tags, NSTAGES deep, one slot per stage after ID.
- Generates per-operand forwarding selects, load-use stalls (load data ready at a configurable stage), memory-wait freezes and CSR serialisation, plus flush control for branches, exceptions and returns.
- Sits beside the decode stage; drives the operand muxes in EX and the IF/ID stall and per-stage invalidate inputs.

Parameters:
- NSTAGES, 3: post-ID stages tracked (1=EX, 2=MEM, 3=WB).
- REG_W, 5: register index width.
- LOAD_FWD_STAGE, 2: first stage whose load result may be forwarded; must satisfy 1 < LOAD_FWD_STAGE <= NSTAGES.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_W  source registers
- id_rs1_used, id_rs2_used  in  1  operand actually read
- id_rd  in  REG_W  destination register
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  ID instruction is a load
- id_is_csr  in  1  ID instruction is a CSR access, or another serialising instruction
- mem_wait  in  1  data memory not ready; whole pipe holds
- took_branch  in  1  branch or jump taken, resolved in EX
- excep_or_ret  in  1  exception, mret or sret taken, resolved in MEM
- fwd_sel_a, fwd_sel_b  out  $clog2(NSTAGES+1)  0 = register file, k = stage k
- stall_if, stall_id  out  1  hold PC and the IF/ID register
- flush_if, flush_id, flush_ex, flush_mem  out  1  invalidate that stage's register
- csr_busy  out  1  FSM in CSR_DRAIN
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Shadow slot fields: valid, rd, we, is_load. Slot k is the instruction in stage k.
- reset_n=0 at a clock edge:
  - all slots are cleared, the FSM goes to RUN and stall_count goes to 0.
  - While reset_n is low, every output is forced to 0 combinationally.
- Forwarding (combinational from slots and ID inputs):
  - fwd_sel_a is the smallest k with slot[k].valid, slot[k].we, slot[k].rd==id_rs1, id_rs1!=0 and id_rs1_used; otherwise 0.
  - fwd_sel_b is identical for rs2.
  - The nearest (youngest) producer always wins.
- Load-use: the hazard is asserted when the winning slot k for either operand has is_load and k < LOAD_FWD_STAGE.
- FSM states:
  - RUN: normal operation. Goes to LOAD_STALL on a load-use hazard. Goes to CSR_DRAIN when id_valid && id_is_csr and any slot is valid.
  - LOAD_STALL:
    - stall_if=stall_id=1; a bubble enters slot 1.
    - Re-evaluated every cycle; returns to RUN when no hazard remains.
    - Latency is LOAD_FWD_STAGE-1 cycles for a dependent instruction directly behind the load.
  - CSR_DRAIN:
    - stall_if=stall_id=1; bubbles enter slot 1.
    - Returns to RUN when all slots are invalid; the CSR instruction issues in that cycle.
    - csr_busy=1.
- Shift rule on each edge with mem_wait=0:
  - slot[k] <= slot[k-1].
  - slot[1] <= ID tag if id_valid, not stalled and not flushed; otherwise a bubble.
- mem_wait=1: slots and FSM state are frozen, stall_if=stall_id=1, and no flushes are generated. mem_wait has the highest priority after reset.
- took_branch (priority over excep_or_ret, stall and drain):
  - flush_if=flush_id=1 in the same cycle.
  - slot 1 receives a bubble; the FSM returns to RUN.
- excep_or_ret:
  - flush_id=flush_ex=flush_mem=1; flush_if=0, because the trap vector is fetching.
  - slots 1 and 2 are cleared on the edge; the FSM returns to RUN.
- Stall/flush outputs are combinational from the FSM state, slots and current inputs. No output depends on negedge logic.
- stall_count increments on every cycle with stall_id=1 and saturates at 2^CNT_W-1.
- Register 0 is never a hazard, regardless of the we flag.

Decomposition:
- Shared package hazard_pkg holds:
  - the slot typedef (valid, rd, we, is_load);
  - the FSM state encoding (RUN, LOAD_STALL, CSR_DRAIN);
  - a FWD_RF=0 constant.
- One sub-module, hazard_fwd_match: purely combinational priority match of one source register against the slot array, returning the select and is_load. Instantiated twice.

Test Plan:
- add x5 then add x6,x5,x1 back-to-back -> fwd_sel_a=1; then with one bubble between -> fwd_sel_a=2; stall_id stays 0.
- lw x5 followed by add x7,x5,x5 (LOAD_FWD_STAGE=2) -> stall_id=1 for exactly 1 cycle; then fwd_sel_a=fwd_sel_b=2; stall_count=1.
- Writes to x3 in slots 1 and 2, ID reads x3 -> fwd_sel_a=1 (youngest); ID reads x0 with all slots rd=0 -> fwd_sel=0.
- csrrw behind 3 valid ALU ops -> csr_busy=1 and stall_id=1 for 3 cycles; then it issues and slot 1 holds the CSR tag.
- took_branch and excep_or_ret in the same cycle during LOAD_STALL -> flush_if=flush_id=1, flush_ex=0; FSM back in RUN next cycle.
- mem_wait high for 4 cycles mid-stream -> slots unchanged; stall_if=1 throughout; then reset_n low for one edge -> all outputs 0 and slots empty.
